// File: rtl/mem_wb_unit.sv
// rtl/mem_wb_unit.sv - memory/writeback stage with one instruction in flight
// Latches an EX instruction, performs one data-memory access, then emits a one-cycle writeback.
module mem_wb_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_load_op,
    input  logic [2:0]            in_store_op,
    input  logic                  in_need_dstE,
    input  logic                  in_sel_reg,
    input  logic [4:0]            in_rd,
    input  logic [XLEN-1:0]       in_valE,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic                  in_wen_csr,
    input  logic [XLEN-1:0]       in_wen_csr_index,
    input  logic [XLEN-1:0]       in_valE_csr,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_wen,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [XLEN-1:0]       req_wdata,
    output logic [3:0]            req_wmask,
    input  logic                  rsp_valid,
    input  logic [XLEN-1:0]       rsp_rdata,
    output logic                  wb_need_dstE,
    output logic [4:0]            wb_rd,
    output logic [XLEN-1:0]       wb_res,
    output logic                  wb_wen_csr,
    output logic [XLEN-1:0]       wb_wen_csr_index,
    output logic [XLEN-1:0]       wb_valE_csr,
    output logic                  misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    typedef struct packed {
        logic [4:0]      load_op;   // {lhu,lbu,lw,lh,lb}
        logic [2:0]      store_op;  // {sw,sh,sb}
        logic            need;
        logic            sel;
        logic [4:0]      rd;
        logic [XLEN-1:0] vale;
        logic [XLEN-1:0] sdata;
        logic            wen_csr;
        logic [XLEN-1:0] csr_idx;
        logic [XLEN-1:0] csr_val;
    } fields_t;

    state_t          state_q, state_d;
    fields_t         fld_q, fld_d, in_fld, cur;
    logic            mis_q, mis_d, mis_in, mem_in;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_res_q, wb_res_d, wb_idx_q, wb_idx_d, wb_val_q, wb_val_d;
    logic [1:0]      off_q;

    function automatic logic [XLEN-1:0] load_ext(input logic [4:0] op, input logic [1:0] off,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        if (op[0])      load_ext = {{(XLEN-8){b[7]}}, b};
        else if (op[3]) load_ext = {{(XLEN-8){1'b0}}, b};
        else if (op[1]) load_ext = {{(XLEN-16){h[15]}}, h};
        else if (op[4]) load_ext = {{(XLEN-16){1'b0}}, h};
        else            load_ext = w;
    endfunction

    assign in_fld = '{load_op: in_load_op, store_op: in_store_op, need: in_need_dstE,
                      sel: in_sel_reg, rd: in_rd, vale: in_valE, sdata: in_store_data,
                      wen_csr: in_wen_csr, csr_idx: in_wen_csr_index, csr_val: in_valE_csr};
    // Writeback can be entered straight from IDLE, before the latched copy exists.
    assign cur    = (state_q == S_IDLE) ? in_fld : fld_q;
    assign mem_in = (|in_load_op) | (|in_store_op);
    assign mis_in = ((in_load_op[4] | in_load_op[1] | in_store_op[1]) & in_valE[0]) |
                    ((in_load_op[2] | in_store_op[2]) & (|in_valE[1:0]));

    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        mis_d    = mis_q;
        wb_rd_d  = wb_rd_q;
        wb_res_d = wb_res_q;
        wb_idx_d = wb_idx_q;
        wb_val_d = wb_val_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                fld_d   = in_fld;
                mis_d   = mis_in;
                state_d = (mem_in && !mis_in) ? S_REQ : S_WB;
            end
            S_REQ:  if (req_ready) state_d = S_WAIT;
            S_WAIT: if (rsp_valid) state_d = S_WB;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_WB && state_q != S_WB) begin
            wb_rd_d  = cur.rd;
            wb_idx_d = cur.csr_idx;
            wb_val_d = cur.csr_val;
            wb_res_d = cur.sel ? cur.vale : load_ext(cur.load_op, cur.vale[1:0], rsp_rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fld_q    <= '0;
            mis_q    <= 1'b0;
            wb_rd_q  <= '0;
            wb_res_q <= '0;
            wb_idx_q <= '0;
            wb_val_q <= '0;
        end else begin
            state_q  <= state_d;
            fld_q    <= fld_d;
            mis_q    <= mis_d;
            wb_rd_q  <= wb_rd_d;
            wb_res_q <= wb_res_d;
            wb_idx_q <= wb_idx_d;
            wb_val_q <= wb_val_d;
        end
    end

    assign off_q     = fld_q.vale[1:0];
    assign in_ready  = (state_q == S_IDLE);
    assign req_valid = (state_q == S_REQ);
    assign req_wen   = |fld_q.store_op;
    assign req_addr  = {fld_q.vale[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        req_wmask = 4'b0000;
        req_wdata = fld_q.sdata;
        if (fld_q.store_op[0]) begin
            req_wmask = 4'b0001 << off_q;
            req_wdata = {(XLEN/8){fld_q.sdata[7:0]}};
        end else if (fld_q.store_op[1]) begin
            req_wmask = 4'b0011 << off_q;
            req_wdata = {(XLEN/16){fld_q.sdata[15:0]}};
        end else if (fld_q.store_op[2]) begin
            req_wmask = 4'hF;
        end
    end

    assign wb_need_dstE     = (state_q == S_WB) & fld_q.need & ~mis_q;
    assign wb_wen_csr       = (state_q == S_WB) & fld_q.wen_csr & ~mis_q;
    assign misalign         = (state_q == S_WB) & mis_q;
    assign wb_rd            = wb_rd_q;
    assign wb_res           = wb_res_q;
    assign wb_wen_csr_index = wb_idx_q;
    assign wb_valE_csr      = wb_val_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// tb/tb_mem_wb_unit.sv - randomized bench for mem_wb_unit against a behavioural model
module tb_mem_wb_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_load_op = '0;
    logic [2:0]  in_store_op = '0;
    logic        in_need_dstE = 1'b0, in_sel_reg = 1'b0, in_wen_csr = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_valE = '0, in_store_data = '0, in_wen_csr_index = '0, in_valE_csr = '0;
    logic        req_valid, req_ready = 1'b0, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        wb_need_dstE, wb_wen_csr, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res, wb_wen_csr_index, wb_valE_csr;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_wb_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_load_op(in_load_op), .in_store_op(in_store_op), .in_need_dstE(in_need_dstE),
        .in_sel_reg(in_sel_reg), .in_rd(in_rd), .in_valE(in_valE), .in_store_data(in_store_data),
        .in_wen_csr(in_wen_csr), .in_wen_csr_index(in_wen_csr_index), .in_valE_csr(in_valE_csr),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wb_need_dstE(wb_need_dstE), .wb_rd(wb_rd), .wb_res(wb_res), .wb_wen_csr(wb_wen_csr),
        .wb_wen_csr_index(wb_wen_csr_index), .wb_valE_csr(wb_valE_csr), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        in_load_op = 5'($urandom);  in_store_op = 3'($urandom);
        in_need_dstE = 1'($urandom); in_sel_reg = 1'($urandom); in_rd = 5'($urandom);
        in_valE = $urandom; in_store_data = $urandom; in_wen_csr = 1'($urandom);
        in_wen_csr_index = $urandom; in_valE_csr = $urandom;
    endtask

    // Drives one instruction and checks the whole transaction against the model.
    task automatic do_op(input logic [4:0] lop, input logic [2:0] sop, input logic need,
                         input logic sel, input logic [4:0] rd, input logic [31:0] vale,
                         input logic [31:0] sd, input logic wcsr, input logic [31:0] cidx,
                         input logic [31:0] cval, input int rq, input int rs,
                         input logic [31:0] rdata);
        int unsigned off, bval, hval;
        logic        is_mem, mis;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata, e_ld, e_res;
        off    = vale & 3;
        is_mem = (lop != 0) || (sop != 0);
        mis    = (((lop == 5'b10000) || (lop == 5'b00010) || (sop == 3'b010)) && (off % 2 == 1)) ||
                 (((lop == 5'b00100) || (sop == 3'b100)) && (off != 0));
        case (sop)
            3'b001:  begin e_mask = 4'(1 << off); e_wdata = (sd & 32'hFF) * 32'h01010101; end
            3'b010:  begin e_mask = 4'(3 << off); e_wdata = (sd & 32'hFFFF) * 32'h00010001; end
            3'b100:  begin e_mask = 4'hF; e_wdata = sd; end
            default: begin e_mask = 4'h0; e_wdata = sd; end
        endcase
        bval = (rdata >> (8 * off)) & 32'hFF;
        hval = (rdata >> (8 * off)) & 32'hFFFF;
        case (lop)
            5'b00001: e_ld = (bval > 127) ? bval + 32'hFFFFFF00 : bval;
            5'b01000: e_ld = bval;
            5'b00010: e_ld = (hval > 32767) ? hval + 32'hFFFF0000 : hval;
            5'b10000: e_ld = hval;
            default:  e_ld = rdata;
        endcase
        e_res = sel ? vale : e_ld;

        in_load_op = lop; in_store_op = sop; in_need_dstE = need; in_sel_reg = sel; in_rd = rd;
        in_valE = vale; in_store_data = sd; in_wen_csr = wcsr; in_wen_csr_index = cidx;
        in_valE_csr = cval; in_valid = 1'b1;
        #1 check("in_ready_idle", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        if (is_mem && !mis) begin
            for (int k = 0; k <= rq; k++) begin
                req_ready = (k == rq);
                rsp_valid = 1'($urandom);
                rsp_rdata = $urandom;
                @(negedge clk);
                check("req_valid", 32'(req_valid), 1);
                check("req_addr", req_addr, vale & 32'hFFFFFFFC);
                check("req_wen", 32'(req_wen), 32'(sop != 0));
                if (sop != 0) begin
                    check("req_wmask", 32'(req_wmask), 32'(e_mask));
                    check("req_wdata", req_wdata, e_wdata);
                end
                check("in_ready_busy", 32'(in_ready), 0);
                @(posedge clk); #1;
            end
            req_ready = 1'b0;
            for (int k = 0; k <= rs; k++) begin
                rsp_valid = (k == rs);
                rsp_rdata = (k == rs) ? rdata : $urandom;
                req_ready = 1'($urandom);
                @(negedge clk);
                check("req_valid_wait", 32'(req_valid), 0);
                check("wb_need_early", 32'(wb_need_dstE), 0);
                @(posedge clk); #1;
            end
            rsp_valid = 1'b0;
            req_ready = 1'b0;
        end
        @(negedge clk);
        check("wb_need_dstE", 32'(wb_need_dstE), 32'(need && !mis));
        check("wb_wen_csr", 32'(wb_wen_csr), 32'(wcsr && !mis));
        check("misalign", 32'(misalign), 32'(mis));
        check("in_ready_wb", 32'(in_ready), 0);
        check("req_valid_wb", 32'(req_valid), 0);
        if (!mis) begin
            check("wb_rd", 32'(wb_rd), 32'(rd));
            check("wb_csr_index", wb_wen_csr_index, cidx);
            check("wb_valE_csr", wb_valE_csr, cval);
            if (sel || lop != 0) check("wb_res", wb_res, e_res);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("wb_need_after", 32'(wb_need_dstE), 0);
        check("wb_wen_csr_after", 32'(wb_wen_csr), 0);
        check("misalign_after", 32'(misalign), 0);
        check("in_ready_after", 32'(in_ready), 1);
        if (!mis) check("wb_res_hold", wb_res, (sel || lop != 0) ? e_res : wb_res);
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_req_valid", 32'(req_valid), 0);
        check("rst_wb_need", 32'(wb_need_dstE), 0);
        check("rst_wb_res", wb_res, 0);
        check("rst_misalign", 32'(misalign), 0);
        check("rst_req_wmask", 32'(req_wmask), 0);

        // Reset while waiting for a response; a late response must be ignored.
        in_load_op = 5'b00100; in_store_op = 3'b000; in_need_dstE = 1'b1; in_sel_reg = 1'b0;
        in_rd = 5'd7; in_valE = 32'h80000000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; req_ready = 1'b1;
        @(posedge clk); #1 req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_req_valid", 32'(req_valid), 0);
        check("rstw_in_ready", 32'(in_ready), 1);
        rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
        @(posedge clk); #1 rsp_valid = 1'b0;
        @(negedge clk);
        check("rstw_no_wb", 32'(wb_need_dstE), 0);
        check("rstw_in_ready2", 32'(in_ready), 1);

        // Directed cases
        do_op(5'b0, 3'b0, 1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        do_op(5'b00001, 3'b0, 1, 0, 5'd9, 32'h80000003, 0, 0, 0, 0, 0, 0, 32'h80FF1122);
        do_op(5'b01000, 3'b0, 1, 0, 5'd9, 32'h80000003, 0, 0, 0, 0, 0, 0, 32'h80FF1122);
        do_op(5'b0, 3'b010, 0, 1, 5'd0, 32'h80000002, 32'h0000ABCD, 0, 0, 0, 2, 0, 0);
        do_op(5'b00100, 3'b0, 1, 0, 5'd3, 32'h80000002, 0, 0, 0, 0, 0, 0, 32'h55555555);
        do_op(5'b0, 3'b0, 0, 1, 5'd0, 32'h0, 0, 1, 32'h305, 32'h80000100, 0, 0, 0);
        do_op(5'b0, 3'b0, 1, 1, 5'd0, 32'hCAFE0000, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if (kind <= 1)
                do_op(5'b0, 3'b0, 1'($urandom), 1, 5'($urandom), a, $urandom, 1'($urandom),
                      $urandom, $urandom, 0, 0, 0);
            else if (kind <= 6)
                do_op(5'(1 << (kind - 2)), 3'b0, 1, 0, 5'($urandom), a, 0, 1'($urandom),
                      $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            else
                do_op(5'b0, 3'(1 << (kind - 7)), 0, 1, 5'($urandom), a, $urandom, 0,
                      $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
